// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, opcode encodings and FSM state type for muldiv_unit.
// Build option: MULDIV_DIV_EN (see muldiv_unit.sv) does not change anything in this package.
package muldiv_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // rs1 is treated as signed for every op except MULHU, DIVU and REMU.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is signed only for MUL, MULH, DIV and REM (MULHSU takes it unsigned).
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared 128-bit accumulator.
//   multiply: acc = {hi, lo}; lo holds the unconsumed multiplier bits. Add the
//             multiplicand into hi when lo[0] is set, then shift {carry, hi, lo} right.
//   divide:   acc = {remainder, quotient}; shift left, trial-subtract the divisor,
//             keep the difference and set the quotient bit when it does not go negative.
// Build option: MULDIV_DIV_EN; when undefined the divide path is absent and the
// multiply step is produced for every request.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                i_is_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]     i_operand,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [XLEN:0]      w_mul_sum;
    logic [2*XLEN-1:0]  w_mul_next;

    // Multiply: conditional add into the high half, then a 1-bit right shift with carry-in.
    always_comb begin
        w_mul_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_mul_next = {w_mul_sum, i_acc[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN:0]      w_diff;
    logic [2*XLEN-1:0]  w_div_next;

    // Divide: restoring step; the remainder stays below the divisor so 65 bits hold the trial.
    always_comb begin
        w_rem_sh = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, i_operand};
        if (!w_diff[XLEN])
            w_div_next = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
        else
            w_div_next = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end

    // Select the step matching the operation in flight.
    always_comb begin
        o_acc = i_is_div ? w_div_next : w_mul_next;
    end
`else
    logic w_unused_is_div;

    // Only the multiplier exists in this build.
    always_comb begin
        w_unused_is_div = i_is_div;
        o_acc           = w_mul_next;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide, one bit per clock, fixed cadence of
// one operation per 67 cycles regardless of opcode or operand values.
// Build option: MULDIV_DIV_EN defined implements all eight ops; undefined removes the
// divider, and funct3[2]=1 requests still run the full sequence but finish with
// result=0 and no register write.
// Handshake: start is taken only when the FSM is in IDLE (inputs are captured on that
// edge and ignored afterwards); busy is high from acceptance through the done cycle;
// done is a one-cycle pulse one edge after the DONE state; regWrite is done qualified
// by rdOut!=0; result/rdOut stay valid from the done cycle until the next accepted start.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     operandA,
    input  logic [XLEN-1:0]     operandB,
    input  logic [4:0]          rdIn,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     result,
    output logic [4:0]          rdOut,
    output logic                regWrite,
    output muldiv_state_t       o_dbg_state
);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opnd;
    logic [2:0]         r_funct3;
    logic [4:0]         r_rd;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [XLEN-1:0]    r_result;
    logic               r_done;

    logic               w_accept;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic [2*XLEN-1:0]  w_step_acc;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_fix_result;
    logic               w_wr_ok;

`ifdef MULDIV_DIV_EN
    logic               r_ovf;
    logic               w_ovf_in;
    logic [XLEN-1:0]    w_quot_s;
    logic [XLEN-1:0]    w_rem_s;
    logic               w_div0;
`endif

    // Sign flags and magnitudes of the incoming operands, as seen at acceptance.
    always_comb begin
        w_sign_a = a_is_signed(funct3) & operandA[XLEN-1];
        w_sign_b = b_is_signed(funct3) & operandB[XLEN-1];
        w_mag_a  = w_sign_a ? -operandA : operandA;
        w_mag_b  = w_sign_b ? -operandB : operandB;
    end

`ifdef MULDIV_DIV_EN
    // The single signed-overflow case -2^63 / -1 is recognised before the operands are lost.
    always_comb begin
        w_ovf_in = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (&operandB);
    end
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state: 64 RUN cycles, one FIX cycle, one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0)
                    w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    muldiv_step u_step (
        .i_is_div   (r_funct3[2]),
        .i_acc      (r_acc),
        .i_operand  (r_opnd),
        .o_acc      (w_step_acc)
    );

    // Datapath: capture on accept, iterate in RUN, register the final value in FIX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_cnt    <= '1;
                r_funct3 <= funct3;
                r_rd     <= rdIn;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
`ifdef MULDIV_DIV_EN
                r_ovf    <= w_ovf_in;
`endif
                if (funct3[2]) begin
                    r_opnd <= w_mag_b;
                    r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                end else begin
                    r_opnd <= w_mag_a;
                    r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                end
            end else if (r_state == ST_RUN) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (r_state == ST_FIX) begin
                r_result <= w_fix_result;
            end
        end
    end

`ifdef MULDIV_DIV_EN
    // Quotient sign follows the operand signs; remainder sign follows the dividend.
    always_comb begin
        w_quot_s = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem_s  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_div0   = (r_opnd == '0);
    end
`endif

    // Fixup: product sign correction, result select and divide special cases.
    always_comb begin
        w_prod       = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        w_fix_result = '0;
        case (r_funct3)
            F3_MUL:                       w_fix_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            F3_DIV, F3_DIVU: begin
                if (w_div0)
                    w_fix_result = '1;
                else if (r_ovf)
                    w_fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else
                    w_fix_result = w_quot_s;
            end
            F3_REM, F3_REMU: begin
                // A zero divisor leaves the untouched dividend in the remainder half.
                if (w_div0)
                    w_fix_result = w_rem_s;
                else if (r_ovf)
                    w_fix_result = '0;
                else
                    w_fix_result = w_rem_s;
            end
`endif
            default: w_fix_result = '0;
        endcase
    end

    // Write permission: divide requests never write when the divider is absent.
    always_comb begin
`ifdef MULDIV_DIV_EN
        w_wr_ok = 1'b1;
`else
        w_wr_ok = ~r_funct3[2];
`endif
    end

    assign busy        = (r_state != ST_IDLE) | r_done;
    assign done        = r_done;
    assign result      = r_result;
    assign rdOut       = r_rd;
    assign regWrite    = r_done & (r_rd != 5'd0) & w_wr_ok;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (default build or MULDIV_DIV_EN).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [2:0]     funct3;
    logic [63:0]    operandA;
    logic [63:0]    operandB;
    logic [4:0]     rdIn;
    logic           busy;
    logic           done;
    logic [63:0]    result;
    logic [4:0]     rdOut;
    logic           regWrite;
    muldiv_state_t  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int LAT = 66;

    muldiv_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .funct3      (funct3),
        .operandA    (operandA),
        .operandB    (operandB),
        .rdIn        (rdIn),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .rdOut       (rdOut),
        .regWrite    (regWrite),
        .o_dbg_state (dbg_state)
    );

    // Clock.
    always #5 clock = ~clock;

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // Driver: issue one op, scramble inputs after acceptance, return what the DUT shows
    // in the done cycle. Returns lat=-1 if done never appears. Ends on the edge after done.
    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, output int lat, output logic [63:0] res,
                          output logic [4:0] rd_o, output logic wr);
        @(negedge clock);
        funct3 = f3; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        operandA = {$urandom, $urandom};
        operandB = {$urandom, $urandom};
        rdIn = 5'($urandom_range(0, 31));
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        res = result; rd_o = rdOut; wr = regWrite;
        @(posedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (regWrite !== 1'b0) begin n_errors++; $display("FAIL reset_regwrite: got %b expected 0", regWrite); end
        n_checks++; if (result !== 64'd0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (rdOut !== 5'd0) begin n_errors++; $display("FAIL reset_rdout: got %0d expected 0", rdOut); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        reset = 1'b1;
    endtask

    task automatic test_multiply();
        int lat; logic [63:0] res; logic [4:0] rdo; logic wr;
        logic [2:0] f3; logic [63:0] a, b, exp;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin f3 = F3_MUL;    a = 64'd7;                   b = 64'hFFFF_FFFF_FFFF_FFFD; exp = 64'hFFFF_FFFF_FFFF_FFEB; end
                1: begin f3 = F3_MULHU;  a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; exp = 64'hFFFF_FFFF_FFFF_FFFE; end
                2: begin f3 = F3_MULH;   a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; exp = 64'd0; end
                3: begin f3 = F3_MULHSU; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; exp = 64'hFFFF_FFFF_FFFF_FFFF; end
                4: begin f3 = F3_MUL;    a = 64'h0000_0001_0000_0001; b = 64'h0000_0001_0000_0001; exp = 64'h0000_0002_0000_0001; end
                5: begin f3 = F3_MULHU;  a = 64'h0000_0001_0000_0001; b = 64'h0000_0001_0000_0001; exp = 64'd1; end
                default: begin f3 = F3_MULH; a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; exp = 64'h4000_0000_0000_0000; end
            endcase
            run_op(f3, a, b, 5'(i + 5), lat, res, rdo, wr);
            n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL mul[%0d] latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (res !== exp) begin n_errors++; $display("FAIL mul[%0d] result: got %h expected %h", i, res, exp); end
            n_checks++; if (rdo !== 5'(i + 5)) begin n_errors++; $display("FAIL mul[%0d] rdout: got %0d expected %0d", i, rdo, i + 5); end
            n_checks++; if (wr !== 1'b1) begin n_errors++; $display("FAIL mul[%0d] regwrite: got %b expected 1", i, wr); end
            if (i == 0) begin
                @(negedge clock);
                n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mul_done_single: got %b expected 0", done); end
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mul_busy_fall: got %b expected 0", busy); end
            end
        end
    endtask

    task automatic test_divide();
        int lat; logic [63:0] res; logic [4:0] rdo; logic wr;
        logic [2:0] f3; logic [63:0] a, b, exp;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin f3 = F3_DIV;  a = 64'hFFFF_FFFF_FFFF_FFEC; b = 64'd6; exp = 64'hFFFF_FFFF_FFFF_FFFD; end
                1: begin f3 = F3_REM;  a = 64'hFFFF_FFFF_FFFF_FFEC; b = 64'd6; exp = 64'hFFFF_FFFF_FFFF_FFFE; end
                2: begin f3 = F3_DIVU; a = 64'd20; b = 64'd6; exp = 64'd3; end
                3: begin f3 = F3_REMU; a = 64'd20; b = 64'd6; exp = 64'd2; end
                4: begin f3 = F3_DIV;  a = 64'd123; b = 64'd0; exp = 64'hFFFF_FFFF_FFFF_FFFF; end
                5: begin f3 = F3_REM;  a = 64'd123; b = 64'd0; exp = 64'd123; end
                6: begin f3 = F3_DIVU; a = 64'd123; b = 64'd0; exp = 64'hFFFF_FFFF_FFFF_FFFF; end
                7: begin f3 = F3_REMU; a = 64'd123; b = 64'd0; exp = 64'd123; end
                8: begin f3 = F3_DIV;  a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; exp = 64'h8000_0000_0000_0000; end
                default: begin f3 = F3_REM; a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; exp = 64'd0; end
            endcase
            if (!DIV_EN) exp = 64'd0;
            run_op(f3, a, b, 5'd3, lat, res, rdo, wr);
            n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (res !== exp) begin n_errors++; $display("FAIL div[%0d] result: got %h expected %h", i, res, exp); end
            n_checks++; if (rdo !== 5'd3) begin n_errors++; $display("FAIL div[%0d] rdout: got %0d expected 3", i, rdo); end
            n_checks++; if (wr !== DIV_EN) begin n_errors++; $display("FAIL div[%0d] regwrite: got %b expected %b", i, wr, DIV_EN); end
        end
    endtask

    task automatic test_back_to_back();
        int k; bit found;
        @(negedge clock);
        funct3 = F3_MUL; operandA = 64'd7; operandB = 64'hFFFF_FFFF_FFFF_FFFD; rdIn = 5'd5; start = 1'b1;
        @(posedge clock);                       // edge E
        #1 start = 1'b0;
        repeat (9) @(posedge clock);            // edge E+9
        @(negedge clock);
        funct3 = F3_MULHU; operandA = 64'd100; operandB = 64'd100; rdIn = 5'd9; start = 1'b1;
        @(posedge clock);                       // edge E+10, must be ignored
        #1 start = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy_mid: got %b expected 1", busy); end
        k = 10; found = 0;
        while (k < 200 && !found) begin
            @(posedge clock); k++;
            @(negedge clock);
            if (done === 1'b1) found = 1;
        end
        n_checks++; if (k !== LAT) begin n_errors++; $display("FAIL b2b_latency1: got %0d expected %0d", k, LAT); end
        n_checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_errors++; $display("FAIL b2b_result1: got %h expected ffffffffffffffeb", result); end
        n_checks++; if (rdOut !== 5'd5) begin n_errors++; $display("FAIL b2b_rdout1: got %0d expected 5", rdOut); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy_done_cycle: got %b expected 1", busy); end
        // Second op presented in the done cycle so it is sampled at E+67.
        funct3 = F3_MUL; operandA = 64'd3; operandB = 64'd4; rdIn = 5'd0; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept_e67: got busy=%b expected 1", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
        k = 0; found = 0;
        while (k < 200 && !found) begin
            @(posedge clock); k++;
            @(negedge clock);
            if (done === 1'b1) found = 1;
        end
        n_checks++; if (k !== LAT) begin n_errors++; $display("FAIL b2b_latency2: got %0d expected %0d", k, LAT); end
        n_checks++; if (result !== 64'd12) begin n_errors++; $display("FAIL b2b_result2: got %h expected c", result); end
        n_checks++; if (regWrite !== 1'b0) begin n_errors++; $display("FAIL b2b_rd0_regwrite: got %b expected 0", regWrite); end
        @(posedge clock);
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res; logic [4:0] rdo; logic wr; bit seen;
        @(negedge clock);
        funct3 = F3_DIV; operandA = 64'hFFFF_FFFF_FFFF_FFEC; operandB = 64'd6; rdIn = 5'd7; start = 1'b1;
        @(posedge clock);                       // edge E
        #1 start = 1'b0;
        repeat (30) @(posedge clock);           // edge E+30
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        n_checks++; if (result !== 64'd0) begin n_errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
        n_checks++; if (rdOut !== 5'd0) begin n_errors++; $display("FAIL rstmid_rdout: got %0d expected 0", rdOut); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_pulse: got activity=%b expected 0", seen); end
        run_op(F3_MUL, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFA, 5'd9, lat, res, rdo, wr);
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL rstmid_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (res !== 64'd30) begin n_errors++; $display("FAIL rstmid_result2: got %h expected 1e", res); end
        n_checks++; if (rdo !== 5'd9) begin n_errors++; $display("FAIL rstmid_rdout2: got %0d expected 9", rdo); end
        n_checks++; if (wr !== 1'b1) begin n_errors++; $display("FAIL rstmid_regwrite2: got %b expected 1", wr); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; funct3 = 3'd0;
        operandA = 64'd0; operandB = 64'd0; rdIn = 5'd0;
        test_reset();
        test_multiply();
        test_divide();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV64M multiply/divide unit sitting between the register bank read ports and its write-back port. It consumes the two 64-bit source operands plus the destination register index, iterates one bit per clock, and produces a 64-bit result with a one-cycle write-enable strobe for the register bank. The main datapath holds off issue while `busy` is high.

## Interface
- `XLEN`, default 64: operand/result width; only 64 is supported.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only while `busy`=0.
- `funct3`  in  3: operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operandA`  in  64: rs1 value (multiplicand / dividend).
- `operandB`  in  64: rs2 value (multiplier / divisor).
- `rdIn`  in  5: destination index, captured with operands.
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  64: final value, held until next accepted start.
- `rdOut`  out  5: captured destination index.
- `regWrite`  out  1: write strobe for the register bank; equals `done`, except forced 0 when `rdOut`=0.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: `busy`=0. On `start`=1: latch `funct3`, `rdIn`, and operand magnitudes with sign flags. Load counter=63. Go to RUN.
  - RUN: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle. Decrement counter. Go to FIX after the step taken at counter=0 (64 steps).
  - FIX: apply sign correction and special cases, register `result`. Go to DONE.
  - DONE: `done`=1 for one cycle. Go to IDLE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are used internally; the 128-bit product or the quotient is negated when operand signs differ; the remainder takes the dividend's sign.
- Result select:
  - MUL: product[63:0].
  - MULH/MULHSU/MULHU: product[127:64].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases, resolved in FIX:
  - Divisor 0: quotient = all ones; remainder = operandA.
  - DIV with -2^63 / -1: quotient = -2^63; REM result = 0.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- Input changes after acceptance have no effect.

## Timing
- Reset (`reset`=0, async) values: state IDLE; `busy`, `done`, `regWrite`, `result`, and `rdOut` all 0. Internal accumulators and counter are cleared.
- Reset mid-operation aborts the operation immediately. No `done` pulse is produced, and the unit is ready in IDLE on the first edge after release.
- Fixed latency for every funct3 and operand value, with no early-out:
  - `start` sampled at edge E.
  - `busy`=1 from E through E+66.
  - RUN covers edges E+1..E+64; FIX is at E+65.
  - `done`/`regWrite` high in the cycle between E+66 and E+67.
- `busy` falls at E+67. The earliest next accepted `start` is at edge E+67, so there is one operation per 67 cycles.
- `result` and `rdOut` are valid in the `done` cycle and remain stable until the next accepted start.

## Configuration
- `MULDIV_DIV_EN` defined: all eight operations are implemented as above.
- `MULDIV_DIV_EN` undefined: the divider datapath and remainder register are removed.
  - funct3[2]=1 requests are still accepted and follow the same FSM and latency.
  - They produce `result`=0 and `regWrite`=0, with `done` still pulsed, so the register bank is unchanged.
  - Multiply behaviour is identical in both builds.

## Structure
- Package `muldiv_pkg` holds:
  - `XLEN`;
  - funct3 localparams: `F3_MUL`..`F3_REMU`;
  - FSM state typedef `muldiv_state_t`;
  - counter width constant (6 bits).
- Sub-module `muldiv_step`: combinational single iteration.
  - Multiply: conditional add of the multiplicand, then right shift of the 128-bit accumulator.
  - Divide: left shift of remainder:quotient, trial subtract, restore.
  - The top level owns the FSM, the registers, and sign/special-case fixup.

## Test plan
- MUL A=7, B=-3 (0xFFFF_FFFF_FFFF_FFFD), rdIn=5 -> `done` at E+66, result 0xFFFF_FFFF_FFFF_FFEB, rdOut=5, regWrite=1.
- MULHU A=B=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; MULH on the same operands -> 0.
- DIV A=-20, B=6 -> quotient -3; REM on the same operands -> -2; DIVU 20/6 -> 3.
- DIV by 0 with A=123 -> result all ones; REM by 0 -> 123; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM on the same operands -> 0.
- Second `start` pulsed at E+10 with different operands -> ignored, first result unchanged; `start` at E+67 -> accepted. rdIn=0 -> `done`=1, regWrite=0.
- `reset` low at E+30 during DIV -> busy/done/result are 0 immediately, with no `done` pulse. A new MUL after reset release gives the correct result with full latency.
